// File: rtl/mycam_axil_pkg.sv
// Shared response codes, channel FSM state types and address-decode helper
// for the myCam AXI4-Lite register bank.
package mycam_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Number of word-index bits left once the byte-lane bits are dropped.
  function automatic int idx_width(input int addr_width, input int data_width);
    return addr_width - $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mycam_reg_array.sv
// Register storage for the myCam bank: byte-strobe merge, read-only status
// muxing, self-clearing command registers and per-register write strobes.
module mycam_reg_array
  import mycam_axil_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          IW         = 4,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] RO_MASK    = 32'hC0,
  parameter logic [31:0] PULSE_MASK = 32'h01
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   i_wr_en,
  input  logic [IW-1:0]          i_wr_idx,
  input  logic [DW-1:0]          i_wr_data,
  input  logic [DW/8-1:0]        i_wr_strb,
  output logic [1:0]             o_wr_resp,
  input  logic [IW-1:0]          i_rd_idx,
  output logic [DW-1:0]          o_rd_data,
  output logic [1:0]             o_rd_resp,
  input  logic [NUM_REGS*DW-1:0] i_reg_in,
  output logic [NUM_REGS*DW-1:0] o_reg_out,
  output logic [NUM_REGS-1:0]    o_wr_pulse
);

  logic [DW-1:0]       w_view [NUM_REGS];
  logic [NUM_REGS-1:0] w_hit;
  logic                w_wr_legal;

  always_comb begin
    w_wr_legal = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_wr_idx == IW'(i) && !RO_MASK[i]) w_wr_legal = 1'b1;
    end
  end

  assign o_wr_resp = w_wr_legal ? RESP_OKAY : RESP_SLVERR;

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign w_hit[gi] = i_wr_en && (i_wr_idx == IW'(gi)) && !RO_MASK[gi];

    if (RO_MASK[gi]) begin : g_ro
      // Status words bypass storage; fabric already owns them.
      assign w_view[gi]               = i_reg_in[gi*DW +: DW];
      assign o_reg_out[gi*DW +: DW]   = '0;
    end else begin : g_rw
      logic [DW-1:0] r_val;
      logic          w_unused_in;

      always_ff @(posedge clk) begin
        if (srst) begin
          r_val <= '0;
        end else if (w_hit[gi]) begin
          for (int b = 0; b < DW / 8; b++) begin
            if (i_wr_strb[b]) r_val[b*8 +: 8] <= i_wr_data[b*8 +: 8];
          end
        end else if (PULSE_MASK[gi]) begin
          r_val <= '0;
        end
      end

      assign w_view[gi]             = r_val;
      assign o_reg_out[gi*DW +: DW] = r_val;
      assign w_unused_in            = ^i_reg_in[gi*DW +: DW];
    end
  end

  assign o_wr_pulse = w_hit;

  // Out-of-range indices fall through to zero data with SLVERR.
  always_comb begin
    o_rd_data = '0;
    o_rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_rd_idx == IW'(i)) begin
        o_rd_data = w_view[i];
        o_rd_resp = RESP_OKAY;
      end
    end
  end

endmodule

// File: rtl/mycam_axil_regbank.sv
// AXI4-Lite slave front end for the myCam register bank: independent write
// and read channel FSMs around the mycam_reg_array storage.
module mycam_axil_regbank
  import mycam_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 8,
  parameter logic [31:0] RO_MASK            = 32'hC0,
  parameter logic [31:0] PULSE_MASK         = 32'h01
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int LSB = $clog2(DW / 8);
  localparam int IW  = idx_width(AW, DW);

  if (DW != 32 && DW != 64) begin : g_bad_dw
    $error("mycam_axil_regbank: C_S_AXI_DATA_WIDTH must be 32 or 64");
  end
  if (IW < 1 || NUM_REGS < 1 || NUM_REGS > 32 || NUM_REGS > (1 << IW)) begin : g_bad_nregs
    $error("mycam_axil_regbank: NUM_REGS does not fit the word-index field");
  end
  if ((RO_MASK & PULSE_MASK) != 32'd0) begin : g_bad_masks
    $error("mycam_axil_regbank: RO_MASK and PULSE_MASK overlap");
  end

  wr_state_t         r_wr_state;
  logic              r_awready;
  logic              r_wready;
  logic              r_aw_held;
  logic              r_w_held;
  logic [IW-1:0]     r_wr_idx;
  logic [DW-1:0]     r_wdata;
  logic [DW/8-1:0]   r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  rd_state_t         r_rd_state;
  logic              r_arready;
  logic              r_rvalid;
  logic [DW-1:0]     r_rdata;
  logic [1:0]        r_rresp;

  logic              w_commit;
  logic [1:0]        w_wr_resp;
  logic [IW-1:0]     w_rd_idx;
  logic [DW-1:0]     w_rd_data;
  logic [1:0]        w_rd_resp;
  logic              w_unused;

  assign w_commit = (r_wr_state == WR_IDLE) && r_aw_held && r_w_held;
  assign w_rd_idx = s00_axi_araddr[AW-1:LSB];
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[LSB-1:0], s00_axi_araddr[LSB-1:0]};

  // Write channel: AW and W latch independently, commit once both are held.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_wr_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (w_commit) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_bvalid   <= 1'b1;
            r_bresp    <= w_wr_resp;
            r_wr_state <= WR_RESP;
          end else begin
            if (r_awready && s00_axi_awvalid) begin
              r_awready <= 1'b0;
              r_aw_held <= 1'b1;
              r_wr_idx  <= s00_axi_awaddr[AW-1:LSB];
            end else if (!r_aw_held) begin
              r_awready <= 1'b1;
            end
            if (r_wready && s00_axi_wvalid) begin
              r_wready <= 1'b0;
              r_w_held <= 1'b1;
              r_wdata  <= s00_axi_wdata;
              r_wstrb  <= s00_axi_wstrb;
            end else if (!r_w_held) begin
              r_wready <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (s00_axi_bready) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read channel: data is captured at the AR handshake edge, so a commit on
  // the same edge is not yet visible.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (r_arready && s00_axi_arvalid) begin
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_resp;
            r_rd_state <= RD_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s00_axi_rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  mycam_reg_array #(
    .DW         (DW),
    .IW         (IW),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK),
    .PULSE_MASK (PULSE_MASK)
  ) u_regs (
    .clk        (s00_axi_aclk),
    .srst       (s00_axi_areset),
    .i_wr_en    (w_commit),
    .i_wr_idx   (r_wr_idx),
    .i_wr_data  (r_wdata),
    .i_wr_strb  (r_wstrb),
    .o_wr_resp  (w_wr_resp),
    .i_rd_idx   (w_rd_idx),
    .o_rd_data  (w_rd_data),
    .o_rd_resp  (w_rd_resp),
    .i_reg_in   (reg_in),
    .o_reg_out  (reg_out),
    .o_wr_pulse (wr_pulse)
  );

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_mycam_axil_regbank.sv
// Scoreboard bench for mycam_axil_regbank: directed scenarios plus random
// traffic checked against an array-based model of the register map.
module tb_mycam_axil_regbank;

  localparam int          DW   = 32;
  localparam int          AW   = 6;
  localparam int          NR   = 8;
  localparam logic [31:0] RO_M = 32'hC0;
  localparam logic [31:0] PU_M = 32'h01;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             areset;
  logic [AW-1:0]    awaddr;
  logic             awvalid, awready;
  logic [DW-1:0]    wdata;
  logic [DW/8-1:0]  wstrb;
  logic             wvalid, wready;
  logic [1:0]       bresp;
  logic             bvalid, bready;
  logic [AW-1:0]    araddr;
  logic             arvalid, arready;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;
  logic             rvalid, rready;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in;
  logic [NR-1:0]    wr_pulse;

  mycam_axil_regbank #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .NUM_REGS           (NR),
    .RO_MASK            (RO_M),
    .PULSE_MASK         (PU_M)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (3'b000),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (3'b000),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg_out         (reg_out),
    .reg_in          (reg_in),
    .wr_pulse        (wr_pulse)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          pulse_exp = 0;
  int          pulse_seen = 0;
  logic [31:0] model [NR];
  logic [1:0]  exp_b [$];
  rexp_t       exp_r [$];
  logic        bp_en = 1'b1;
  logic        bready_force = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no DUT response, expected one within the cycle budget", name);
  endtask

  // Response backpressure, applied just after each rising edge.
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bready = bp_en ? ($urandom_range(0, 3) != 0) : bready_force;
      rready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever a response handshake is pending.
  initial begin
    logic [1:0] eb;
    rexp_t      er;
    forever begin
      @(negedge clk);
      if (!areset) begin
        pulse_seen += $countones(wr_pulse);
        if (bvalid && bready) begin
          $display("B   resp=%0d", bresp);
          if (exp_b.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL b_unexpected: got resp %0d, expected no response", bresp);
          end else begin
            eb = exp_b.pop_front();
            chk("bresp", 64'(bresp), 64'(eb));
          end
        end
        if (rvalid && rready) begin
          $display("R   data=%h resp=%0d", rdata, rresp);
          if (exp_r.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL r_unexpected: got data %h, expected no response", rdata);
          end else begin
            er = exp_r.pop_front();
            chk("rdata", 64'(rdata), 64'(er.data));
            chk("rresp", 64'(rresp), 64'(er.resp));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_aw(input logic [AW-1:0] a, input int dly);
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1;
    awaddr  = a;
    awvalid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (awready) begin
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        return;
      end
    end
    awvalid = 1'b0;
    fail("aw_timeout");
  endtask

  task automatic do_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input int dly);
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (wready) begin
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        return;
      end
    end
    wvalid = 1'b0;
    fail("w_timeout");
  endtask

  task automatic do_ar(input logic [AW-1:0] a, input int dly);
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1;
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        return;
      end
    end
    arvalid = 1'b0;
    fail("ar_timeout");
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 200; n++) begin
      if (exp_b.size() == 0 && exp_r.size() == 0) break;
      @(negedge clk);
    end
    if (n == 200) begin
      fail("drain_timeout");
      exp_b.delete();
      exp_r.delete();
    end
  endtask

  // Reference register map: RO and unmapped words reject writes, pulse
  // registers read back as zero once the write has passed.
  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx >= NR || RO_M[idx]) begin
      exp_b.push_back(2'b10);
    end else begin
      exp_b.push_back(2'b00);
      pulse_exp++;
      if (PU_M[idx]) model[idx] = '0;
      else for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic check_map();
    for (int i = 0; i < NR; i++) begin
      if (!RO_M[i]) chk($sformatf("reg_out%0d", i), 64'(reg_out[i*DW +: DW]), 64'(model[i]));
    end
    chk("wr_pulse_count", 64'(pulse_seen), 64'(pulse_exp));
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd);
    model_write(int'(a[AW-1:2]), d, s);
    fork
      do_aw(a, awd);
      do_w(d, s, wd);
    join
    wait_drain();
    @(negedge clk);
    check_map();
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int dly);
    int    idx;
    rexp_t e;
    idx = int'(a[AW-1:2]);
    if (idx >= NR) begin
      e.data = '0; e.resp = 2'b10;
    end else if (RO_M[idx]) begin
      e.data = reg_in[idx*DW +: DW]; e.resp = 2'b00;
    end else begin
      e.data = model[idx]; e.resp = 2'b00;
    end
    exp_r.push_back(e);
    do_ar(a, dly);
    wait_drain();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    chk("ready_low_after_release", 64'({awready, wready, arready}), 64'(3'b000));
    @(negedge clk);
    chk("ready_high_after_release", 64'({awready, wready, arready}), 64'(3'b111));
  endtask

  initial begin
    int         n;
    logic       hold_ok;
    logic [5:0] a;

    areset  = 1'b1;
    awaddr  = '0; awvalid = 1'b0;
    wdata   = '0; wstrb = '0; wvalid = 1'b0;
    araddr  = '0; arvalid = 1'b0;
    reg_in  = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    reg_in[6*DW +: DW] = $urandom;
    reg_in[7*DW +: DW] = $urandom;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_handshake", 64'({awready, wready, arready, bvalid, rvalid}), 64'(0));
    chk("rst_resp_data", 64'({bresp, rresp, rdata}), 64'(0));
    chk("rst_reg_out", 64'(|reg_out), 64'(0));
    chk("rst_wr_pulse", 64'(wr_pulse), 64'(0));
    release_reset();

    // Basic write/readback of the first four words
    for (int i = 0; i < 4; i++) axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(6'(i * 4), 0);
    chk("reg_out1_plan", 64'(reg_out[DW +: DW]), 64'h2);

    // Byte strobes
    axi_write(6'h04, 32'h0, 4'hF, 0, 0);
    axi_write(6'h04, 32'hAABBCCDD, 4'b0101, 1, 0);
    axi_read(6'h04, 0);
    chk("strobe_merge_plan", 64'(reg_out[DW +: DW]), 64'h00BB00DD);

    // W three cycles after AW, response held under bready low
    bp_en = 1'b0;
    bready_force = 1'b0;
    model_write(1, 32'hCAFE0001, 4'hF);
    fork
      begin
        fork
          do_aw(6'h04, 0);
          do_w(32'hCAFE0001, 4'hF, 3);
        join
      end
      begin
        for (n = 0; n < 50; n++) begin
          @(negedge clk);
          if (wr_pulse[1]) break;
        end
        if (n == 50) fail("commit_timeout");
        @(negedge clk);
        chk("bvalid_after_commit", 64'(bvalid), 64'(1));
        hold_ok = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (!bvalid || bresp != 2'b00 || awready || wready) hold_ok = 1'b0;
        end
        chk("b_hold_stable", 64'(hold_ok), 64'(1));
      end
    join
    bready_force = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    @(negedge clk);
    chk("ready_rearm", 64'({awready, wready}), 64'(2'b11));
    wait_drain();
    check_map();
    bp_en = 1'b1;

    // Read-only and unmapped words
    reg_in[6*DW +: DW] = 32'h5A5A5A5A;
    axi_write(6'h18, 32'h1, 4'hF, 0, 0);
    axi_read(6'h18, 0);
    axi_read(6'h3C, 0);

    // Self-clearing register
    bp_en = 1'b0;
    bready_force = 1'b1;
    model_write(0, 32'h1, 4'hF);
    fork
      begin
        fork
          do_aw(6'h00, 0);
          do_w(32'h1, 4'hF, 0);
        join
      end
      begin
        for (n = 0; n < 50; n++) begin
          @(negedge clk);
          if (wr_pulse[0]) break;
        end
        if (n == 50) fail("pulse_commit_timeout");
        @(negedge clk);
        chk("pulse_visible", 64'(reg_out[0 +: DW]), 64'h1);
        @(negedge clk);
        chk("pulse_cleared", 64'(reg_out[0 +: DW]), 64'h0);
      end
    join
    wait_drain();
    bp_en = 1'b1;
    axi_read(6'h00, 0);

    // Reset while a write response is pending
    bp_en = 1'b0;
    bready_force = 1'b0;
    pulse_exp++;
    fork
      do_aw(6'h08, 0);
      do_w(32'h12345678, 4'hF, 0);
    join
    for (n = 0; n < 20; n++) begin
      if (bvalid) break;
      @(negedge clk);
    end
    chk("bvalid_before_reset", 64'(bvalid), 64'(1));
    areset = 1'b1;
    @(negedge clk);
    chk("bvalid_after_reset", 64'(bvalid), 64'(0));
    chk("reg_out_after_reset", 64'(|reg_out), 64'(0));
    chk("ready_in_reset", 64'({awready, wready, arready}), 64'(0));
    exp_b.delete();
    exp_r.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    release_reset();
    bp_en = 1'b1;
    axi_write(6'h08, 32'h600DF00D, 4'hF, 1, 2);
    axi_read(6'h08, 1);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) reg_in[7*DW +: DW] = $urandom;
      if ($urandom_range(0, 3) == 0) reg_in[6*DW +: DW] = $urandom;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
